// File: rtl/wpm_pkg.sv
// Shared types and defaults for the waveform period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wpm_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } wpm_state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizes an asynchronous level into clk and flags its rising/falling edges.
// Latency: STAGES cycles from sig_in sample to rise/fall (rise/fall are single-cycle).
// Backpressure: none, free-running.
module sig_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_sh;
    logic              prev;

    // Reset value 0 means a line that is low at release never looks like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sh <= '0;
            prev    <= 1'b0;
        end else begin
            sync_sh <= {sync_sh[STAGES-2:0], sig_in};
            prev    <= sync_sh[STAGES-1];
        end
    end

    assign sync = sync_sh[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/wave_period_meter.sv
// Measures high and low phase lengths (in clk cycles) of an asynchronous periodic signal.
// Latency: result registered one cycle after the period-terminating rise is detected.
// Backpressure: valid/ready; a result completing while one is stalled is dropped with an overrun pulse.
module wave_period_meter
    import wpm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             sat,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wpm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;
    logic [CNT_W-1:0] hi_cnt;
    logic             hi_sat;
    logic             sync_lvl_unused;
    logic             rise;
    logic             fall;

    sig_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .sync   (sync_lvl_unused),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cnt_sat    <= 1'b0;
            hi_cnt     <= '0;
            hi_sat     <= 1'b0;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            sat        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (meas_valid && meas_ready)
                meas_valid <= 1'b0;

            // Disable aborts the measurement but leaves any pending result for the consumer.
            if (!en) begin
                state   <= IDLE;
                cnt     <= '0;
                cnt_sat <= 1'b0;
                hi_cnt  <= '0;
                hi_sat  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_RISE;
                    WAIT_RISE: begin
                        if (rise) begin
                            state   <= MEAS_HIGH;
                            cnt     <= CNT_ONE;
                            cnt_sat <= 1'b0;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            hi_cnt  <= cnt;
                            hi_sat  <= cnt_sat;
                            cnt     <= CNT_ONE;
                            cnt_sat <= 1'b0;
                            state   <= MEAS_LOW;
                        end else if (cnt == CNT_MAX) begin
                            cnt_sat <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            // Slot is free if empty or being drained this very cycle.
                            if (!meas_valid || meas_ready) begin
                                meas_valid <= 1'b1;
                                high_cnt   <= hi_cnt;
                                low_cnt    <= cnt;
                                sat        <= hi_sat | cnt_sat;
                            end else begin
                                overrun <= 1'b1;
                            end
                            cnt     <= CNT_ONE;
                            cnt_sat <= 1'b0;
                            state   <= MEAS_HIGH;
                        end else if (cnt == CNT_MAX) begin
                            cnt_sat <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_wave_period_meter.sv
// Scoreboard bench: stimulus pushes expected period results, a negedge monitor pops on handshake.
// Two instances (16-bit and 4-bit counters) see identical stimulus.
// Backpressure exercised via random ready, held-ready overrun and disable-with-pending cases.
module tb_wave_period_meter;

    typedef struct {
        int h;
        int l;
        bit s;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic sig_in;
    logic meas_ready;

    logic        v16, s16, o16, b16;
    logic [15:0] h16, l16;
    logic        v4, s4, o4, b4;
    logic [3:0]  h4, l4;

    res_t q16[$];
    res_t q4[$];
    int   checks   = 0;
    int   failures = 0;
    int   ovr[2];
    bit   stall[2];
    int   hold_h[2];
    int   hold_l[2];
    bit   hold_s[2];
    int   ph[64];
    int   pl[64];
    bit   rnd_rdy  = 1'b0;
    int   low_run  = 0;

    always #5 clk = ~clk;

    wave_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .meas_valid(v16), .meas_ready(meas_ready), .high_cnt(h16), .low_cnt(l16),
        .sat(s16), .overrun(o16), .busy(b16)
    );

    wave_period_meter #(.CNT_W(4), .SYNC_STAGES(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .meas_valid(v4), .meas_ready(meas_ready), .high_cnt(h4), .low_cnt(l4),
        .sat(s4), .overrun(o4), .busy(b4)
    );

    // Reference: a period's fields are its phase lengths clamped to the field maximum;
    // sat marks that either phase was longer than the field can hold.
    function automatic res_t model(input int h, input int l, input int w);
        res_t r;
        int   mx;
        mx  = (1 << w) - 1;
        r.h = (h > mx) ? mx : h;
        r.l = (l > mx) ? mx : l;
        r.s = (h > mx) || (l > mx);
        return r;
    endfunction

    function automatic void push_period(input int h, input int l);
        q16.push_back(model(h, l, 16));
        q4.push_back(model(h, l, 4));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic v, input int h, input int l,
                       input logic s, input logic o);
        res_t e;
        bit   empty;
        if (o) ovr[id]++;
        if (stall[id]) begin
            checks++;
            if (!v || h != hold_h[id] || l != hold_l[id] || s != hold_s[id]) begin
                failures++;
                $display("FAIL hold%0d: got v=%0d h=%0d l=%0d s=%0d expected v=1 h=%0d l=%0d s=%0d",
                         id, v, h, l, s, hold_h[id], hold_l[id], hold_s[id]);
            end
        end
        if (v && meas_ready) begin
            checks++;
            empty = (id == 0) ? (q16.size() == 0) : (q4.size() == 0);
            if (empty) begin
                failures++;
                $display("FAIL unexpected%0d: got result h=%0d l=%0d s=%0d expected none", id, h, l, s);
            end else begin
                if (id == 0) e = q16.pop_front();
                else         e = q4.pop_front();
                if (h != e.h || l != e.l || s != e.s) begin
                    failures++;
                    $display("FAIL result%0d: got h=%0d l=%0d s=%0d expected h=%0d l=%0d s=%0d",
                             id, h, l, s, e.h, e.l, e.s);
                end
            end
        end
        stall[id]  = v && !meas_ready;
        hold_h[id] = h;
        hold_l[id] = l;
        hold_s[id] = s;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            mon(0, v16, int'(h16), int'(l16), s16, o16);
            mon(1, v4, int'(h4), int'(l4), s4, o4);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds sig_in at v for n clock samples; optionally jitters ready (never low >2 cycles).
    task automatic drive(input bit v, input int n);
        sig_in = v;
        repeat (n) begin
            if (rnd_rdy) begin
                if (low_run >= 2 || $urandom_range(0, 1) == 1) begin
                    meas_ready = 1'b1;
                    low_run    = 0;
                end else begin
                    meas_ready = 1'b0;
                    low_run++;
                end
            end
            cyc(1);
        end
    endtask

    // Drives n full periods plus a terminating rise; only the first 'keep' results are expected.
    task automatic run_periods(input int n, input int keep);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && i <= keep) push_period(ph[i-1], pl[i-1]);
            drive(1'b1, ph[i]);
            drive(1'b0, pl[i]);
        end
        if (n <= keep) push_period(ph[n-1], pl[n-1]);
        drive(1'b1, 2);
    endtask

    task automatic wait_drain(input string nm);
        int waited;
        waited = 0;
        while ((q16.size() != 0 || q4.size() != 0) && waited < 300) begin
            cyc(1);
            waited++;
        end
        checks++;
        if (q16.size() != 0 || q4.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: got %0d/%0d results outstanding expected 0", nm, q16.size(), q4.size());
            q16.delete();
            q4.delete();
        end
    endtask

    task automatic end_scn();
        en     = 1'b0;
        sig_in = 1'b0;
        cyc(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        ovr[0] = 0;
        ovr[1] = 0;
        rst_n = 1'b0; en = 1'b0; sig_in = 1'b0; meas_ready = 1'b1;
        cyc(3);
        chk("rst_valid", v16, 0);   chk("rst_busy", b16, 0);
        chk("rst_high", h16, 0);    chk("rst_low", l16, 0);
        chk("rst_sat", s16, 0);     chk("rst_ovr", o16, 0);
        chk("rst_valid4", v4, 0);   chk("rst_busy4", b4, 0);
        rst_n = 1'b1;
        cyc(2);

        // 5 high / 3 low repeating
        en = 1'b1;
        cyc(2);
        chk("en_busy", b16, 1);
        for (int i = 0; i < 6; i++) begin ph[i] = 5; pl[i] = 3; end
        run_periods(6, 6);
        wait_drain("5_3");
        end_scn();

        // enable in the middle of a high phase: partial phase must be skipped
        drive(1'b1, 5);
        en = 1'b1;
        drive(1'b1, 5);
        drive(1'b0, 10);
        for (int i = 0; i < 2; i++) begin ph[i] = 10; pl[i] = 10; end
        run_periods(2, 2);
        wait_drain("mid_en");
        end_scn();

        // long high phase saturates the narrow instance
        en = 1'b1;
        cyc(2);
        for (int i = 0; i < 2; i++) begin ph[i] = 20; pl[i] = 2; end
        run_periods(2, 2);
        wait_drain("sat");
        end_scn();

        // random phases with ready held
        en = 1'b1;
        cyc(2);
        for (int i = 0; i < 30; i++) begin
            ph[i] = $urandom_range(1, 20);
            pl[i] = $urandom_range(1, 20);
        end
        run_periods(30, 30);
        wait_drain("rand");
        end_scn();

        // random phases with jittering ready, periods long enough to never drop
        en = 1'b1;
        cyc(2);
        for (int i = 0; i < 20; i++) begin
            ph[i] = $urandom_range(4, 12);
            pl[i] = $urandom_range(4, 12);
        end
        rnd_rdy = 1'b1;
        run_periods(20, 20);
        rnd_rdy = 1'b0;
        meas_ready = 1'b1;
        wait_drain("rand_rdy");
        end_scn();

        // two completions while stalled: first held, second dropped with one overrun
        ovr[0] = 0;
        ovr[1] = 0;
        meas_ready = 1'b0;
        en = 1'b1;
        cyc(2);
        for (int i = 0; i < 2; i++) begin ph[i] = 4; pl[i] = 4; end
        run_periods(2, 1);
        cyc(6);
        chk("ovr_valid", v16, 1);   chk("ovr_high", h16, 4);   chk("ovr_low", l16, 4);
        chk("ovr_valid4", v4, 1);
        chk("ovr_count", ovr[0], 1);
        chk("ovr_count4", ovr[1], 1);
        meas_ready = 1'b1;
        cyc(2);
        chk("ovr_drained", v16, 0);
        wait_drain("ovr");
        end_scn();

        // disable while a result is pending
        meas_ready = 1'b0;
        en = 1'b1;
        cyc(2);
        ph[0] = 6; pl[0] = 5;
        run_periods(1, 1);
        cyc(5);
        en = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("dis_busy", b16, 0);    chk("dis_busy4", b4, 0);
        chk("dis_valid", v16, 1);
        cyc(4);
        chk("dis_valid_hold", v16, 1);
        meas_ready = 1'b1;
        cyc(2);
        wait_drain("dis");
        chk("dis_valid_after", v16, 0);
        sig_in = 1'b0;
        cyc(4);

        // reset during the low phase with a held result
        meas_ready = 1'b0;
        en = 1'b1;
        cyc(2);
        drive(1'b1, 4);
        drive(1'b0, 3);
        drive(1'b1, 4);
        drive(1'b0, 6);
        chk("pre_rst_valid", v16, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", v16, 0);  chk("arst_high", h16, 0);
        chk("arst_low", l16, 0);    chk("arst_busy", b16, 0);
        chk("arst_valid4", v4, 0);  chk("arst_busy4", b4, 0);
        cyc(2);
        meas_ready = 1'b1;
        rst_n = 1'b1;
        cyc(3);
        ph[0] = 5; pl[0] = 4;
        run_periods(1, 1);
        wait_drain("post_rst");
        end_scn();

        chk("final_q16", q16.size(), 0);
        chk("final_q4", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_period_meter.md
WAVE_PERIOD_METER -- requirements
Module: wave_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each period counter and result field.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  measurement enable.
REQ-006 SHALL have port sig_in  input  1  asynchronous periodic waveform under measurement.
REQ-007 SHALL have port meas_valid  output  1  result available.
REQ-008 SHALL have port meas_ready  input  1  consumer accepts result.
REQ-009 SHALL have port high_cnt  output  CNT_W  clk cycles sig_in was high in last full period.
REQ-010 SHALL have port low_cnt  output  CNT_W  clk cycles sig_in was low in last full period.
REQ-011 SHALL have port sat  output  1  either field saturated in the current result.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a completed result is dropped.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL pass sig_in through SYNC_STAGES flops, then compare with one more registered copy; rise = sync & ~prev, fall = ~sync & prev.
REQ-015 SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-016 IDLE -> WAIT_RISE when en=1; WAIT_RISE ignores falls and partial first phase.
REQ-017 WAIT_RISE -> MEAS_HIGH on rise; counter loads 1 in that cycle.
REQ-018 MEAS_HIGH: counter +1 per cycle; on fall, latch counter as high phase, counter loads 1, -> MEAS_LOW.
REQ-019 MEAS_LOW: counter +1 per cycle; on rise, latch counter as low phase, form result, counter loads 1, -> MEAS_HIGH (back-to-back periods, no dead cycle).
REQ-020 Counter SHALL saturate at 2^CNT_W-1, never wrap; saturation in either phase sets sat for that result.
REQ-021 Result SHALL be registered: meas_valid, high_cnt, low_cnt, sat update the cycle after the terminating rise is detected.
REQ-022 Handshake: transfer when meas_valid & meas_ready; outputs SHALL stay stable while meas_valid=1 and meas_ready=0.
REQ-023 Result completing while meas_valid=1 and meas_ready=0 SHALL be discarded and overrun pulses one cycle; held result unchanged.
REQ-024 Result completing in same cycle as a transfer SHALL be loaded (meas_valid stays 1, no overrun).
REQ-025 en=0 in any state SHALL return FSM to IDLE next cycle, clear counter and partial high latch; a pending result SHALL remain until accepted.
REQ-026 Latency sig_in edge to detect: SYNC_STAGES cycles (+ up to one for sampling phase).

Reset
REQ-027 rst_n=0 SHALL asynchronously force FSM=IDLE, sync/prev flops=0, counter=0, meas_valid=0, high_cnt=0, low_cnt=0, sat=0, overrun=0, busy=0.
REQ-028 Reset mid-measurement SHALL discard all partial and pending results; after release, measurement restarts from WAIT_RISE only.
REQ-029 Synchronizer reset value 0 SHALL not produce a false rise if sig_in is low at release; a sig_in high at release is a legal rise.

Structure
REQ-030 Package wpm_pkg SHALL hold the FSM state enum, CNT_W default, and SYNC_STAGES default.
REQ-031 Synchronizer plus edge detector SHALL be sub-module sig_sync_edge (outputs sync, rise, fall); FSM, counter, result register in top.

Verification
REQ-032 sig_in high 5 / low 3 cycles repeating, ready=1 -> results high_cnt=5, low_cnt=3, sat=0 every 8 cycles.
REQ-033 Enable mid-high phase, sig_in 10/10 -> first result discarded partial; first reported high_cnt=10, low_cnt=10.
REQ-034 CNT_W=4, sig_in high 20 / low 2 -> high_cnt=15, low_cnt=2, sat=1.
REQ-035 meas_ready=0 across two completed periods 4/4 -> first result held unchanged, overrun pulses once at second completion.
REQ-036 rst_n low during MEAS_LOW -> all outputs 0 immediately; after release, next valid only after one full rise-to-rise period.
REQ-037 en dropped with result pending, ready=0 -> busy=0 next cycle, meas_valid stays 1 until ready=1 transfer.
